// File: rtl/cmac_pkg.sv
// cmac_pkg: shared types and Q11.21 helpers for the complex-MAC result writer.
// Holds the writer FSM encoding, accumulator sizing and the overflow test.
package cmac_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_WRITE,
      S_DONE
   } state_t;

   localparam int          FRAC_BITS = 21;
   localparam logic [31:0] ONE       = 32'h0020_0000;

   function automatic int acc_w(input int nbit, input int nacc);
      return nbit + $clog2(nacc);
   endfunction

   // True when v does not fit in a signed nbit-wide field.
   function automatic logic sat_ovf(input logic signed [63:0] v,
                                    input int nbit);
      logic signed [63:0] mx;
      mx = (64'sd1 <<< (nbit - 1)) - 64'sd1;
      return (v > mx) || (v < (-mx - 64'sd1));
   endfunction

endpackage

// File: rtl/cmac_sat_acc.sv
// cmac_sat_acc: one lane of clear/add accumulation with a saturated view
// of the running sum including the current input.
module cmac_sat_acc
   import cmac_pkg::*;
#(
   parameter int NBIT = 32,
   parameter int AW   = 34
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            add,
   input  logic [NBIT-1:0] din,
   output logic [NBIT-1:0] sat_val,
   output logic            ovf
);

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sum;

   assign sum = acc + AW'(signed'(din));
   assign ovf = sat_ovf(64'(sum), NBIT);

   always_comb begin
      sat_val = sum[NBIT-1:0];
      if (ovf) begin
         sat_val = sum[AW-1] ? {1'b1, {(NBIT-1){1'b0}}}
                             : {1'b0, {(NBIT-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/cmac_result_writer.sv
// cmac_result_writer: accumulates NACC complex products per result and
// writes each saturated result to sequential (wrapping) memory addresses.
module cmac_result_writer
   import cmac_pkg::*;
#(
   parameter int NDIR = 4,
   parameter int NBIT = 32,
   parameter int NACC = 4
) (
   input  logic            clk_top,
   input  logic            rst_top,
   input  logic            start,
   input  logic [NDIR-1:0] base_addr,
   input  logic [NDIR:0]   num_res,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [NBIT-1:0] in_real,
   input  logic [NBIT-1:0] in_imag,
   output logic            wr_en,
   output logic [NDIR-1:0] wr_addr,
   output logic [NBIT-1:0] wr_real,
   output logic [NBIT-1:0] wr_imag,
   output logic            busy,
   output logic            done,
   output logic            sat_flag
);

   localparam int AW = acc_w(NBIT, NACC);
   localparam int CW = $clog2(NACC);
   localparam logic [NDIR:0] IDX_ONE = 1;

   state_t          state;
   state_t          nxt;
   logic [NDIR-1:0] base_q;
   logic [NDIR:0]   num_q;
   logic [NDIR:0]   idx_q;
   logic [CW-1:0]   cnt_q;
   logic            hs;
   logic            last;
   logic            accept;
   logic            idx_last;
   logic            clr;
   logic [NBIT-1:0] re_sat;
   logic [NBIT-1:0] im_sat;
   logic            re_ovf;
   logic            im_ovf;

   assign hs       = in_valid & in_ready;
   assign last     = hs && (cnt_q == CW'(NACC - 1));
   assign accept   = (state == S_IDLE) && start;
   assign idx_last = (idx_q == num_q - IDX_ONE);
   assign clr      = accept || (state == S_WRITE);

   cmac_sat_acc #(.NBIT(NBIT), .AW(AW)) u_re (
      .clk     (clk_top),
      .rst_n   (rst_top),
      .clr     (clr),
      .add     (hs),
      .din     (in_real),
      .sat_val (re_sat),
      .ovf     (re_ovf)
   );

   cmac_sat_acc #(.NBIT(NBIT), .AW(AW)) u_im (
      .clk     (clk_top),
      .rst_n   (rst_top),
      .clr     (clr),
      .add     (hs),
      .din     (in_imag),
      .sat_val (im_sat),
      .ovf     (im_ovf)
   );

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (start) nxt = (num_res == '0) ? S_DONE : S_ACC;
         S_ACC:   if (last) nxt = S_WRITE;
         S_WRITE: nxt = idx_last ? S_DONE : S_ACC;
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // Status strobes are decoded from the next state so they stay registered.
   always_ff @(posedge clk_top or negedge rst_top) begin
      if (!rst_top) begin
         state    <= S_IDLE;
         base_q   <= '0;
         num_q    <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_real  <= '0;
         wr_imag  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sat_flag <= 1'b0;
      end else begin
         state    <= nxt;
         in_ready <= (nxt == S_ACC);
         wr_en    <= (nxt == S_WRITE);
         busy     <= (nxt != S_IDLE);
         done     <= (nxt == S_DONE);
         if (accept) begin
            base_q   <= base_addr;
            num_q    <= num_res;
            idx_q    <= '0;
            cnt_q    <= '0;
            sat_flag <= 1'b0;
         end
         if (hs) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (last) begin
            wr_addr <= base_q + idx_q[NDIR-1:0];
            wr_real <= re_sat;
            wr_imag <= im_sat;
            if (re_ovf || im_ovf) begin
               sat_flag <= 1'b1;
            end
         end
         if (state == S_WRITE) begin
            cnt_q <= '0;
            idx_q <= idx_q + IDX_ONE;
         end
      end
   end

endmodule

// File: tb/tb_cmac_result_writer.sv
// tb_cmac_result_writer: random and directed jobs checked against a
// queue-based model of grouped, clamped complex sums.
module tb_cmac_result_writer;

   localparam int NDIR = 4;
   localparam int NBIT = 32;
   localparam int NACC = 4;
   localparam longint MAXV = 64'sh7FFF_FFFF;
   localparam longint MINV = -64'sh8000_0000;

   logic            clk_top = 1'b0;
   logic            rst_top = 1'b1;
   logic            start = 1'b0;
   logic [NDIR-1:0] base_addr = '0;
   logic [NDIR:0]   num_res = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [NBIT-1:0] in_real = '0;
   logic [NBIT-1:0] in_imag = '0;
   logic            wr_en;
   logic [NDIR-1:0] wr_addr;
   logic [NBIT-1:0] wr_real;
   logic [NBIT-1:0] wr_imag;
   logic            busy;
   logic            done;
   logic            sat_flag;

   cmac_result_writer #(.NDIR(NDIR), .NBIT(NBIT), .NACC(NACC)) dut (
      .clk_top   (clk_top),
      .rst_top   (rst_top),
      .start     (start),
      .base_addr (base_addr),
      .num_res   (num_res),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_real   (wr_real),
      .wr_imag   (wr_imag),
      .busy      (busy),
      .done      (done),
      .sat_flag  (sat_flag)
   );

   always #5 clk_top = ~clk_top;

   typedef struct {
      int          addr;
      logic [31:0] re;
      logic [31:0] im;
   } wr_t;

   wr_t         exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_wr_cyc = 0;
   int          n_wr = 0;
   logic [31:0] last_re = '0;
   logic [31:0] last_im = '0;
   logic [3:0]  last_addr = '0;
   bit          prev_wr = 1'b0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] clamp(input longint s);
      if (s > MAXV) return 32'h7FFF_FFFF;
      if (s < MINV) return 32'h8000_0000;
      return s[31:0];
   endfunction

   function automatic logic [31:0] rnd_val();
      logic [31:0] v;
      case ($urandom_range(2))
         0: v = $urandom;
         1: v = $urandom_range(32'h01FF_FFFF) - 32'h0100_0000;
         default: v = $urandom_range(1) ? 32'h7F00_0000 + $urandom_range(32'hFFFFFF)
                                        : 32'h8000_0000 + $urandom_range(32'hFFFFFF);
      endcase
      return v;
   endfunction

   always @(posedge clk_top) cyc++;

   always @(negedge clk_top) begin : cmp
      wr_t e;
      if (rst_top && prev_wr && !wr_en && exp_q.size() > 0)
         chk("ready_after_write", in_ready, 1);
      if (rst_top && wr_en) begin
         n_wr++;
         chk("ready_low_in_write", in_ready, 0);
         chk("busy_in_write", busy, 1);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0d want none", wr_addr);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(wr_addr), 64'(e.addr));
            chk("wr_real", 64'(wr_real), 64'(e.re));
            chk("wr_imag", 64'(wr_imag), 64'(e.im));
         end
         last_re     = wr_real;
         last_im     = wr_imag;
         last_addr   = wr_addr;
         last_wr_cyc = cyc;
      end
      prev_wr = rst_top && wr_en;
   end

   // mode 0 random, 1 basic, 2 saturate, 3 real 1.0 only
   task automatic run_job(input int base, input int num, input int gap_pct,
                          input bit spam, input int mode);
      logic [31:0] pr[$];
      logic [31:0] pi[$];
      bit          exp_sat;
      int          idx;
      int          budget;
      int          wr0;
      exp_sat = 1'b0;
      for (int i = 0; i < num * NACC; i++) begin
         case (mode)
            1: begin pr.push_back(32'h0020_0000); pi.push_back(32'hFFF0_0000); end
            2: begin pr.push_back(32'h7FFF_FFFF); pi.push_back(32'h8000_0000); end
            3: begin pr.push_back(32'h0020_0000); pi.push_back(32'h0); end
            default: begin pr.push_back(rnd_val()); pi.push_back(rnd_val()); end
         endcase
      end
      for (int r = 0; r < num; r++) begin
         longint sr;
         longint si;
         wr_t    w;
         sr = 0;
         si = 0;
         for (int k = 0; k < NACC; k++) begin
            sr += longint'(signed'(pr[r*NACC+k]));
            si += longint'(signed'(pi[r*NACC+k]));
         end
         if (sr > MAXV || sr < MINV || si > MAXV || si < MINV) exp_sat = 1'b1;
         w.addr = (base + r) % 16;
         w.re   = clamp(sr);
         w.im   = clamp(si);
         exp_q.push_back(w);
      end
      wr0 = n_wr;
      @(negedge clk_top);
      base_addr = 4'(base);
      num_res   = 5'(num);
      start     = 1'b1;
      @(negedge clk_top);
      start     = 1'b0;
      base_addr = 4'($urandom);
      num_res   = 5'($urandom);
      chk("busy_after_start", busy, 1);
      if (num == 0) begin
         chk("empty_done", done, 1);
         chk("empty_sat", sat_flag, 0);
         @(negedge clk_top);
         chk("empty_busy_low", busy, 0);
         chk("empty_no_write", 64'(n_wr - wr0), 0);
         return;
      end
      chk("ready_after_start", in_ready, 1);
      idx = 0;
      budget = 0;
      while (idx < num * NACC && budget < 2000) begin
         in_valid = ($urandom_range(99) >= gap_pct);
         in_real  = in_valid ? pr[idx] : 32'($urandom);
         in_imag  = in_valid ? pi[idx] : 32'($urandom);
         if (spam) begin
            start     = ($urandom_range(3) == 0);
            base_addr = 4'($urandom);
            num_res   = 5'($urandom);
         end
         if (in_valid && in_ready) idx++;
         @(negedge clk_top);
         budget++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      budget   = 0;
      while (!done && budget < 40) begin
         @(negedge clk_top);
         budget++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done want done");
         return;
      end
      chk("done_latency", 64'(cyc - last_wr_cyc), 1);
      chk("writes_drained", 64'(exp_q.size()), 0);
      chk("write_count", 64'(n_wr - wr0), 64'(num));
      chk("sat_flag", sat_flag, exp_sat);
      @(negedge clk_top);
      chk("done_one_cycle", done, 0);
      chk("busy_low", busy, 0);
   endtask

   initial begin
      #1 rst_top = 1'b0;
      repeat (2) @(negedge clk_top);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", 64'(wr_addr), 0);
      chk("rst_wr_real", 64'(wr_real), 0);
      chk("rst_wr_imag", 64'(wr_imag), 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sat", sat_flag, 0);
      rst_top = 1'b1;

      run_job(0, 1, 0, 1'b0, 1);
      chk("basic_real", 64'(last_re), 64'h0080_0000);
      chk("basic_imag", 64'(last_im), 64'hFFC0_0000);
      chk("basic_addr", 64'(last_addr), 0);
      chk("basic_sat", sat_flag, 0);

      run_job(2, 1, 0, 1'b0, 2);
      chk("sat_real", 64'(last_re), 64'h7FFF_FFFF);
      chk("sat_imag", 64'(last_im), 64'h8000_0000);
      repeat (3) @(negedge clk_top);
      chk("sat_sticky", sat_flag, 1);

      run_job(7, 0, 0, 1'b0, 0);

      run_job(14, 4, 0, 1'b0, 3);
      chk("wrap_last_addr", 64'(last_addr), 1);
      chk("wrap_real", 64'(last_re), 64'h0080_0000);

      for (int j = 0; j < 12; j++)
         run_job($urandom_range(15), $urandom_range(1, 6),
                 $urandom_range(60), 1'b1, 0);

      @(negedge clk_top);
      base_addr = 4'd5;
      num_res   = 5'd2;
      start     = 1'b1;
      @(negedge clk_top);
      start     = 1'b0;
      in_valid  = 1'b1;
      in_real   = 32'h0123_4567;
      in_imag   = 32'h0765_4321;
      repeat (2) @(negedge clk_top);
      in_valid  = 1'b0;
      void'(exp_q.size());
      #2 rst_top = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_wr_en", wr_en, 0);
      chk("mid_rst_wr_real", 64'(wr_real), 0);
      chk("mid_rst_wr_imag", 64'(wr_imag), 0);
      chk("mid_rst_wr_addr", 64'(wr_addr), 0);
      chk("mid_rst_sat", sat_flag, 0);
      chk("mid_rst_done", done, 0);
      repeat (2) @(negedge clk_top);
      rst_top = 1'b1;

      run_job(9, 1, 20, 1'b0, 1);
      chk("post_rst_real", 64'(last_re), 64'h0080_0000);
      chk("post_rst_addr", 64'(last_addr), 9);

      repeat (3) @(negedge clk_top);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cmac_result_writer.md
# cmac_result_writer

Receiving end of the complex-product datapath: consumes the stream of signed Q11.21 complex products (real/imaginary pairs), accumulates NACC consecutive products into one complex dot-product term, saturates it, and writes it to the result memory at a sequenced address. It is the memory-side counterpart of the address generator that issues operand reads, and closes the matrix-multiply loop by storing each completed element.

## Interface
- NDIR, 4, result-memory address width (2^NDIR entries)
- NBIT, 32, data width of product inputs and stored results (signed Q11.21)
- NACC, 4, products accumulated per result; power of two, ≥ 2
- clk_top  in  1  clock; all state updates on rising edge
- rst_top  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to begin a job; honoured only in IDLE
- base_addr  in  NDIR  first result address, latched on accepted start
- num_res  in  NDIR+1  number of results in the job (0..2^NDIR), latched on accepted start
- in_valid  in  1  product available on in_real/in_imag
- in_ready  out  1  writer accepts a product this cycle
- in_real  in  NBIT  signed Q11.21 real part of product
- in_imag  in  NBIT  signed Q11.21 imaginary part of product
- wr_en  out  1  result-memory write strobe
- wr_addr  out  NDIR  write address
- wr_real  out  NBIT  saturated real result
- wr_imag  out  NBIT  saturated imaginary result
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job completion
- sat_flag  out  1  sticky: any result saturated since last accepted start

## Operation
- States: IDLE, ACC, WRITE, DONE.
- IDLE: in_ready=0. start=1 → latch base_addr/num_res, clear accumulators, product count, result index and sat_flag; go ACC if num_res≠0, else DONE.
- ACC: in_ready=1. Each handshake (in_valid & in_ready) adds in_real/in_imag to separate accumulators of width NBIT+log2(NACC); count increments. The NACC-th handshake → WRITE. in_valid low: hold.
- WRITE: in_ready=0; wr_en=1 for exactly one cycle; wr_addr=(base+result index) mod 2^NDIR (wraps 2^NDIR−1 → 0); wr_real/wr_imag = accumulator clamped to [−2^(NBIT−1), 2^(NBIT−1)−1]; any clamp sets sat_flag. Then clear accumulators/count; if index = num_res−1 → DONE, else index+1 → ACC.
- DONE: done=1 for one cycle → IDLE.
- start while busy: ignored, no effect on latched job.
- in_valid in IDLE/WRITE/DONE: not accepted, no side effect.
- Reset (any time, including mid-job): immediate return to IDLE; partial accumulation discarded, no write issued.

## Timing
- All outputs registered. Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_real=0, wr_imag=0, busy=0, done=0, sat_flag=0.
- start sampled at edge k → busy and in_ready high from k+1.
- NACC-th handshake at edge k → wr_en high in cycle k+1 → in_ready high again from k+2 (one bubble per result).
- Final write at cycle k → done high in cycle k+1, busy low from k+2; new start accepted from k+2.
- num_res=0: start at edge k → done in cycle k+1, no wr_en.
- Peak throughput: NACC products per NACC+1 cycles.

## Structure
- Package cmac_pkg: state encoding, Q11.21 constants (fraction bits 21, ONE = 0x00200000), accumulator guard-bit width function, saturation function.
- One sub-module cmac_sat_acc: a single-lane clear/add/saturate accumulator, instantiated twice (real, imaginary). FSM, counters and address logic stay in cmac_result_writer.

## Test plan
- Basic: NACC=4, base 0, num 1, four products (0x00200000, 0xFFF00000) → one write, addr 0, wr_real=0x00800000, wr_imag=0xFFC00000, done one cycle later, sat_flag=0.
- Saturation: four products real 0x7FFFFFFF, imag 0x80000000 → wr_real=0x7FFFFFFF, wr_imag=0x80000000, sat_flag=1 until next start.
- Address wrap: base 14, num 4, 16 products of real 1.0 → writes at 14, 15, 0, 1, each wr_real=0x00800000; exactly four wr_en pulses.
- Backpressure/gaps: random in_valid gaps and start pulses while busy → results identical to gap-free run, job parameters unchanged, one in_ready bubble per write.
- Reset mid-job: assert rst_top after 2 of 4 products → all outputs at reset values asynchronously, no write; fresh job after release produces correct first result.
- Empty job: num 0 → done pulse one cycle after start, wr_en never asserted.
